// File: rtl/map_latch_pkg.sv
// rtl/map_latch_pkg.sv - shared types, save-state map and helpers for map_latch_gen
package map_latch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    ARMED = 2'd2
  } m2_state_t;

  localparam logic [7:0] SST_CHR = 8'd0;
  localparam logic [7:0] SST_PRG = 8'd1;
  localparam logic [7:0] SST_MIR = 8'd2;
  localparam logic [7:0] SST_IDX = 8'd127;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [3:0] bit_rev4(input logic [3:0] v, input int w);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/map_latch_gen_m2_filt.sv
// rtl/map_latch_gen_m2_filt.sv - M2 synchroniser, glitch filter and bus capture
module m2_filt
  import map_latch_pkg::*;
#(
  parameter int FILT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m2,
  input  logic        force_idle,
  input  logic        rw,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  input  logic [7:0]  prg,
  output logic        fall,
  output logic        cap_rw,
  output logic [15:0] cap_addr,
  output logic [7:0]  cap_data,
  output logic [7:0]  cap_prg
);

  localparam logic [3:0] FILT_C = 4'(FILT);

  m2_state_t  state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       fall_n;
  logic       m2_q1, m2_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      m2_q1    <= 1'b0;
      m2_s     <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      fall     <= 1'b0;
      cap_rw   <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
      cap_prg  <= '0;
    end else begin
      m2_q1 <= m2;
      m2_s  <= m2_q1;
      state <= state_n;
      cnt   <= cnt_n;
      fall  <= fall_n;
      // Keep refreshing while high so the values from the end of the phase win.
      if (m2_s) begin
        cap_rw   <= rw;
        cap_addr <= addr;
        cap_data <= data;
        cap_prg  <= prg;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fall_n  = 1'b0;
    if (force_idle) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (m2_s) begin
            cnt_n   = 4'd1;
            state_n = (FILT_C <= 4'd1) ? ARMED : HIGH;
          end
        end
        HIGH: begin
          if (m2_s) begin
            cnt_n = (cnt >= FILT_C) ? cnt : cnt + 4'd1;
            if (cnt_n >= FILT_C) state_n = ARMED;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        ARMED: begin
          if (!m2_s) begin
            state_n = IDLE;
            cnt_n   = '0;
            fall_n  = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/map_latch_gen.sv
// rtl/map_latch_gen.sv - parametrised single-latch CHR/PRG/mirroring bank mapper
module map_latch_gen
  import map_latch_pkg::*;
#(
  parameter int          CHR_BITS = 2,
  parameter int          PRG_BITS = 0,
  parameter int          PRG_LSB  = 4,
  parameter int          MIR_BIT  = -1,
  parameter int          CHR_REV  = 1,
  parameter logic [15:0] REG_BASE = 16'h6000,
  parameter logic [15:0] REG_MASK = 16'hE000,
  parameter int          FILT     = 4,
  localparam int         PW       = (PRG_BITS > 0) ? PRG_BITS : 1
) (
  input  logic                clk,
  input  logic                map_rst,
  input  logic                cpu_m2,
  input  logic                cpu_rw,
  input  logic [15:0]         cpu_addr,
  input  logic [7:0]          cpu_data,
  input  logic [7:0]          prg_do,
  input  logic                cfg_bus_cf,
  input  logic [7:0]          cfg_map_idx,
  input  logic                sst_act,
  input  logic                sst_we_reg,
  input  logic [7:0]          sst_addr,
  input  logic [7:0]          sst_dato,
  output logic [7:0]          sst_di,
  output logic [CHR_BITS-1:0] chr_bank,
  output logic [PW-1:0]       prg_bank,
  output logic                mir_sel,
  output logic                wr_pulse
);

  localparam int MIR_IDX = (MIR_BIT < 0) ? 0 : MIR_BIT;

  logic          fall, cap_rw;
  logic [15:0]   cap_addr;
  logic [7:0]    cap_data, cap_prg;

  m2_filt #(.FILT(FILT)) u_filt (
    .clk        (clk),
    .rst        (map_rst),
    .m2         (cpu_m2),
    .force_idle (sst_act),
    .rw         (cpu_rw),
    .addr       (cpu_addr),
    .data       (cpu_data),
    .prg        (prg_do),
    .fall       (fall),
    .cap_rw     (cap_rw),
    .cap_addr   (cap_addr),
    .cap_data   (cap_data),
    .cap_prg    (cap_prg)
  );

  logic          hit, commit;
  logic [7:0]    d;
  logic [3:0]    chr_pad, chr_rev4;
  logic [CHR_BITS-1:0] chr_field;
  logic [PW-1:0] prg_field;
  logic          mir_field;

  assign hit    = (cap_addr & REG_MASK) == REG_BASE;
  assign commit = fall & ~cap_rw & hit & ~sst_act;

  // On a conflicting board the ROM drives the bus too, so only bits both agree on survive.
  assign d = cap_data & ((cfg_bus_cf & cap_addr[15]) ? cap_prg : 8'hFF);

  assign chr_pad   = 4'(d[CHR_BITS-1:0]);
  assign chr_rev4  = bit_rev4(chr_pad, CHR_BITS);
  assign chr_field = (CHR_REV != 0) ? chr_rev4[CHR_BITS-1:0] : d[CHR_BITS-1:0];

  generate
    if (PRG_BITS > 0) begin : g_prg
      assign prg_field = d[PRG_LSB +: PW];
    end else begin : g_no_prg
      assign prg_field = '0;
    end
    if (MIR_BIT >= 0) begin : g_mir
      assign mir_field = d[MIR_IDX];
    end else begin : g_no_mir
      assign mir_field = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (map_rst) begin
      chr_bank <= '0;
      prg_bank <= '0;
      mir_sel  <= 1'b0;
      wr_pulse <= 1'b0;
    end else begin
      wr_pulse <= 1'b0;
      if (sst_act) begin
        if (sst_we_reg) begin
          case (sst_addr)
            SST_CHR: chr_bank <= sst_dato[CHR_BITS-1:0];
            SST_PRG: prg_bank <= (PRG_BITS > 0) ? sst_dato[PW-1:0] : '0;
            SST_MIR: mir_sel  <= (MIR_BIT >= 0) ? sst_dato[0] : 1'b0;
            default: ;
          endcase
        end
      end else if (commit) begin
        chr_bank <= chr_field;
        prg_bank <= prg_field;
        mir_sel  <= mir_field;
        wr_pulse <= 1'b1;
      end
    end
  end

  always_comb begin
    sst_di = 8'hFF;
    case (sst_addr)
      SST_CHR: sst_di = 8'(chr_bank);
      SST_PRG: sst_di = 8'(prg_bank);
      SST_MIR: sst_di = {7'b0, mir_sel};
      SST_IDX: sst_di = cfg_map_idx;
      default: sst_di = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_map_latch_gen.sv
// tb/tb_map_latch_gen.sv - randomized self-checking bench for map_latch_gen
module tb_map_latch_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        map_rst = 1'b1;
  logic        cpu_m2 = 1'b0;
  logic        cpu_rw = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic [7:0]  prg_do = '0;
  logic        cf_a = 1'b0;
  logic        cf_b = 1'b1;
  logic [7:0]  map_idx = 8'h57;
  logic        sst_act = 1'b0;
  logic        sst_we_reg = 1'b0;
  logic [7:0]  sst_addr = '0;
  logic [7:0]  sst_dato = '0;

  logic [7:0]  di_a, di_b;
  logic [1:0]  chr_a, chr_b, prg_b;
  logic [0:0]  prg_a;
  logic        mir_a, mir_b, pulse_a, pulse_b;

  map_latch_gen u_a (
    .clk(clk), .map_rst(map_rst), .cpu_m2(cpu_m2), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .prg_do(prg_do),
    .cfg_bus_cf(cf_a), .cfg_map_idx(map_idx), .sst_act(sst_act),
    .sst_we_reg(sst_we_reg), .sst_addr(sst_addr), .sst_dato(sst_dato),
    .sst_di(di_a), .chr_bank(chr_a), .prg_bank(prg_a), .mir_sel(mir_a),
    .wr_pulse(pulse_a)
  );

  map_latch_gen #(
    .CHR_BITS(2), .PRG_BITS(2), .PRG_LSB(4), .MIR_BIT(7), .CHR_REV(0),
    .REG_BASE(16'h8000), .REG_MASK(16'h8000), .FILT(4)
  ) u_b (
    .clk(clk), .map_rst(map_rst), .cpu_m2(cpu_m2), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .prg_do(prg_do),
    .cfg_bus_cf(cf_b), .cfg_map_idx(map_idx), .sst_act(sst_act),
    .sst_we_reg(sst_we_reg), .sst_addr(sst_addr), .sst_dato(sst_dato),
    .sst_di(di_b), .chr_bank(chr_b), .prg_bank(prg_b), .mir_sel(mir_b),
    .wr_pulse(pulse_b)
  );

  int checks = 0;
  int failures = 0;
  int exp_chr_a = 0, exp_chr_b = 0, exp_prg_b = 0, exp_mir_b = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " chr_a"}, int'(chr_a), exp_chr_a);
    check({tag, " prg_a"}, int'(prg_a), 0);
    check({tag, " mir_a"}, int'(mir_a), 0);
    check({tag, " chr_b"}, int'(chr_b), exp_chr_b);
    check({tag, " prg_b"}, int'(prg_b), exp_prg_b);
    check({tag, " mir_b"}, int'(mir_b), exp_mir_b);
  endtask

  // Reference: a write commits when M2 stayed high at least FILT clocks, it is a
  // write, it decodes into the window and save-state is idle.
  task automatic cpu_cycle(input string tag, input logic [15:0] a, input logic [7:0] dv,
                           input logic rw, input logic [7:0] p, input int hi,
                           input logic cf);
    int  stray_a, stray_b;
    bit  will_a, will_b;
    int  dd;
    @(negedge clk);
    cpu_addr = a; cpu_data = dv; cpu_rw = rw; prg_do = p; cf_b = cf;
    cpu_m2 = 1'b1;
    repeat (hi) @(negedge clk);
    cpu_m2 = 1'b0;
    will_a = (hi >= 4) && !rw && !sst_act && ((a & 16'hE000) == 16'h6000);
    will_b = (hi >= 4) && !rw && !sst_act && (a >= 16'h8000);
    stray_a = 0; stray_b = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 4) begin
        check({tag, " pulse_a@3"}, int'(pulse_a), int'(will_a));
        check({tag, " pulse_b@3"}, int'(pulse_b), int'(will_b));
      end else begin
        stray_a += int'(pulse_a);
        stray_b += int'(pulse_b);
      end
    end
    check({tag, " stray_pulses"}, stray_a + stray_b, 0);
    if (will_a) exp_chr_a = ((int'(dv) & 1) << 1) | ((int'(dv) >> 1) & 1);
    if (will_b) begin
      dd = cf ? (int'(dv) & int'(p)) : int'(dv);
      exp_chr_b = dd % 4;
      exp_prg_b = (dd / 16) % 4;
      exp_mir_b = dd / 128;
    end
    check_outputs(tag);
  endtask

  task automatic sst_write(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    sst_addr = a; sst_dato = v; sst_we_reg = 1'b1;
    @(negedge clk);
    sst_we_reg = 1'b0;
  endtask

  initial begin
    logic [15:0] ra;
    int sel;
    int stray;

    repeat (3) @(negedge clk);
    check("reset chr_a", int'(chr_a), 0);
    check("reset chr_b", int'(chr_b), 0);
    check("reset prg_b", int'(prg_b), 0);
    check("reset mir_b", int'(mir_b), 0);
    check("reset pulse", int'(pulse_a) + int'(pulse_b), 0);
    map_rst = 1'b0;
    @(negedge clk);
    check_outputs("post_reset");

    cpu_cycle("w6000_01", 16'h6000, 8'h01, 1'b0, 8'h00, 10, 1'b1);
    cpu_cycle("w7fff_02", 16'h7FFF, 8'h02, 1'b0, 8'h00, 10, 1'b1);
    cpu_cycle("w8000_a_miss", 16'h8000, 8'h03, 1'b0, 8'hFF, 6, 1'b0);
    cpu_cycle("r6000", 16'h6000, 8'h03, 1'b1, 8'h00, 6, 1'b1);
    cpu_cycle("glitch2", 16'h6000, 8'h03, 1'b0, 8'h00, 2, 1'b1);
    cpu_cycle("glitch3", 16'h6000, 8'h03, 1'b0, 8'h00, 3, 1'b1);
    cpu_cycle("filt_edge4", 16'h6000, 8'h03, 1'b0, 8'h00, 4, 1'b1);
    cpu_cycle("bus_conflict", 16'h8000, 8'h33, 1'b0, 8'h21, 8, 1'b1);
    cpu_cycle("no_conflict", 16'hC123, 8'hB6, 1'b0, 8'h00, 5, 1'b0);

    for (int n = 0; n < 120; n++) begin
      sel = int'($urandom_range(0, 2));
      if (sel == 0)      ra = 16'h6000 | 16'($urandom & 32'h1FFF);
      else if (sel == 1) ra = 16'h8000 | 16'($urandom & 32'h7FFF);
      else               ra = 16'($urandom);
      cpu_cycle($sformatf("rnd%0d", n), ra, 8'($urandom), ($urandom_range(0, 3) == 0),
                8'($urandom), int'($urandom_range(1, 8)), 1'($urandom));
    end

    @(negedge clk);
    sst_act = 1'b1;
    map_idx = 8'($urandom);
    sst_write(8'd0, 8'h02);
    sst_write(8'd1, 8'h03);
    sst_write(8'd2, 8'h01);
    exp_chr_a = 2; exp_chr_b = 2; exp_prg_b = 3; exp_mir_b = 1;
    check_outputs("sst_load");
    cpu_cycle("sst_cpu_ignored", 16'h6000, 8'h01, 1'b0, 8'h00, 8, 1'b0);
    sst_addr = 8'd0;   #1 check("sst_di_a chr", int'(di_a), 2);
    sst_addr = 8'd1;   #1 check("sst_di_a prg", int'(di_a), 0);
    check("sst_di_b prg", int'(di_b), 3);
    sst_addr = 8'd2;   #1 check("sst_di_a mir", int'(di_a), 0);
    check("sst_di_b mir", int'(di_b), 1);
    sst_addr = 8'd127; #1 check("sst_di idx", int'(di_b), int'(map_idx));
    sst_addr = 8'd5;   #1 check("sst_di other", int'(di_a), 8'hFF);
    @(negedge clk);
    sst_act = 1'b0;
    sst_write(8'd0, 8'h01);
    check_outputs("sst_we_inactive");

    @(negedge clk);
    cpu_addr = 16'h6000; cpu_data = 8'h03; cpu_rw = 1'b0; prg_do = 8'h00;
    cpu_m2 = 1'b1;
    repeat (10) @(negedge clk);
    map_rst = 1'b1;
    @(negedge clk);
    cpu_m2 = 1'b0;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      stray += int'(pulse_a) + int'(pulse_b);
    end
    map_rst = 1'b0;
    check("rst_midop pulses", stray, 0);
    exp_chr_a = 0; exp_chr_b = 0; exp_prg_b = 0; exp_mir_b = 0;
    check_outputs("rst_midop");
    cpu_cycle("after_rst", 16'h6000, 8'h01, 1'b0, 8'h00, 6, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/map_latch_gen.md
Name: map_latch_gen

Overview:
- Parametrised successor of our single-latch discrete CHR mappers (87 class): one write-only bank latch at a decoded CPU window that drives CHR bank, PRG bank and mirroring fields.
- Generalised field widths, optional bit-reversal (87-style wiring), optional bus conflicts, M2 glitch filtering and save-state access.
- Runs in the fast mapper clock domain rather than on M2 edges.
- Sits inside a mapper wrapper; its outputs feed chr.addr/prg.addr/ciram_a10 muxing.

Parameters:
- CHR_BITS, 2, width of CHR bank field (1..4).
- PRG_BITS, 0, width of PRG bank field (0..3; 0 = field absent, output tied 0).
- PRG_LSB, 4, data bit position of PRG field LSB.
- MIR_BIT, -1, data bit driving mir_sel (-1 = field absent, mir_sel = 0).
- CHR_REV, 1, 1 = CHR field is bit-reversed data[CHR_BITS-1:0] (87 wiring), 0 = straight.
- REG_BASE, 16'h6000, latch window base.
- REG_MASK, 16'hE000, window mask: hit = (addr & REG_MASK) == REG_BASE.
- FILT, 4, clk cycles M2 must stay high for a cycle to count (1..15).

Ports:
- clk  in  1  mapper clock; synchronous reset is used, active-high.
- map_rst  in  1  synchronous reset, active-high.
- cpu_m2  in  1  CPU M2, asynchronous to clk.
- cpu_rw  in  1  1 = read.
- cpu_addr  in  16  CPU address.
- cpu_data  in  8  CPU data bus.
- prg_do  in  8  PRG ROM output, used for bus conflict.
- cfg_bus_cf  in  1  enable bus-conflict AND.
- cfg_map_idx  in  8  mapper index for save-state byte 127.
- sst_act  in  1  save-state engine active.
- sst_we_reg  in  1  save-state register write strobe, clk-domain.
- sst_addr  in  8  save-state address.
- sst_dato  in  8  save-state write data.
- sst_di  out  8  save-state read data, combinational.
- chr_bank  out  CHR_BITS  CHR bank.
- prg_bank  out  max(PRG_BITS,1)  PRG bank.
- mir_sel  out  1  mirroring select.
- wr_pulse  out  1  one-clk pulse on every latch commit.

Behaviour:
- Reset: chr_bank=0, prg_bank=0, mir_sel=0, wr_pulse=0, FSM=IDLE, filter counter=0, capture regs=0.
- M2 path: 2-flop synchroniser gives m2_s. Each clk with m2_s=1, capture cpu_addr, cpu_data, cpu_rw and prg_do, so the last high-phase values are kept.
- FSM:
  - IDLE: m2_s=1 -> HIGH, cnt=1.
  - HIGH: m2_s=1 -> cnt++; when cnt reaches FILT go to ARMED. m2_s=0 -> IDLE, no commit (glitch).
  - ARMED: m2_s=0 -> IDLE and commit if cap_rw=0 and window hit; m2_s=1 holds.
- Counter saturates at FILT and never wraps.
- Commit data:
  - d = cap_data & (cfg_bus_cf & cap_addr[15] ? cap_prg : 8'hFF).
  - chr_bank = CHR_REV ? bit-reverse(d[CHR_BITS-1:0]) : d[CHR_BITS-1:0].
  - prg_bank = d[PRG_LSB +: PRG_BITS].
  - mir_sel = d[MIR_BIT].
- Latency: outputs and wr_pulse update on the clk edge that follows the clk where ARMED sees m2_s=0. That is 3 clk after the first clk edge sampling raw M2 low.
- Back-to-back CPU writes commit each in order; last write wins.
- Save state:
  - While sst_act=1, CPU commits are suppressed and the FSM is forced to IDLE.
  - sst_we_reg with sst_addr 0/1/2 loads chr_bank/prg_bank/mir_sel from sst_dato low bits, with no reversal.
  - sst_di: addr 0 = chr_bank zero-extended, 1 = prg_bank, 2 = mir_sel, 127 = cfg_map_idx, others 8'hFF.
  - sst_we_reg with sst_act=0 is ignored.
- map_rst has priority over sst and commits. Reset mid-cycle discards any pending commit; the next M2 high phase starts fresh.
- Absent fields are tied 0, read back as 0, and ignore sst writes.

Decomposition:
- Package map_latch_pkg holds:
  - FSM enum (IDLE, HIGH, ARMED).
  - Save-state address constants SST_CHR=0, SST_PRG=1, SST_MIR=2, SST_IDX=127.
  - Bit-reverse function.
- Sub-module m2_filt: synchroniser, counter and FSM. Outputs a commit strobe plus the captured bus. The top level does decode, field extraction and save state.

Test Plan:
- Defaults (CHR_REV=1): write $6000=8'h01, M2 high 10 clk -> chr_bank=2'b10, wr_pulse exactly once, 3 clk after M2 falls; then $7FFF=8'h02 -> chr_bank=2'b01.
- Decode and read: write $8000=8'h03 and a read at $6000 -> no commit, chr_bank unchanged, wr_pulse stays 0.
- Glitch: M2 high 2 clk (FILT=4) during write $6000=8'h03 -> no commit; a following normal write commits.
- Bus conflict (CHR_REV=0, PRG_BITS=2, cfg_bus_cf=1, REG_BASE=$8000, REG_MASK=$8000): write $8000=8'h33, prg_do=8'h21 -> d=8'h21, chr_bank=2'b01, prg_bank=2'b10.
- Save state: sst_act=1, sst_we_reg addr0=8'h02 -> chr_bank=2; CPU write $6000 meanwhile ignored; sst_addr 127 reads cfg_map_idx, addr 5 reads 8'hFF.
- Reset mid-op: assert map_rst while ARMED -> all outputs 0, no wr_pulse; next write commits normally.
